// File: rtl/source_operand_router.sv
// Routes one issue-stage operand per cycle into one of NUM_CH per-channel FIFOs.
// Operands with an out-of-range select are consumed, discarded and counted.
module source_operand_router #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_CH-1:0]         out_valid,
  output logic [NUM_CH*DATA_W-1:0]  out_data,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [NUM_CH*OCC_W-1:0]   occupancy,
  output logic                      drop_err,
  output logic [CNT_W-1:0]          drop_cnt,
  input  logic                      err_clr
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high;
  // valid never depends on ready, and in_ready never depends on out_ready.

  logic [DATA_W-1:0] mem_q  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wptr_q [NUM_CH];
  logic [PTR_W-1:0]  wptr_d [NUM_CH];
  logic [PTR_W-1:0]  rptr_q [NUM_CH];
  logic [PTR_W-1:0]  rptr_d [NUM_CH];
  logic [OCC_W-1:0]  occ_q  [NUM_CH];
  logic [OCC_W-1:0]  occ_d  [NUM_CH];
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              sel_legal;
  logic              drop;

  always_comb begin
    in_ready  = 1'b1;
    sel_legal = 1'b0;
    push      = '0;
    pop       = '0;
    full      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c] = (occ_q[c] == OCC_W'(DEPTH));
      pop[c]  = (occ_q[c] != '0) && out_ready[c];
      if (in_sel == SEL_W'(c)) begin
        sel_legal = 1'b1;
        in_ready  = !full[c];
        push[c]   = in_valid && !full[c];
      end
    end
    drop = in_valid && !sel_legal;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      occ_d[c]  = occ_q[c];
      if (push[c]) begin
        wptr_d[c] = (wptr_q[c] == PTR_W'(DEPTH - 1)) ? '0 : wptr_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rptr_d[c] = (rptr_q[c] == PTR_W'(DEPTH - 1)) ? '0 : rptr_q[c] + 1'b1;
      end
      if (push[c] && !pop[c]) begin
        occ_d[c] = occ_q[c] + 1'b1;
      end else if (pop[c] && !push[c]) begin
        occ_d[c] = occ_q[c] - 1'b1;
      end
    end
  end

  // err_clr wins over a drop in the same cycle; that drop is not recorded.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (drop) begin
      err_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= '0;
        end
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
        if (push[c]) begin
          mem_q[c][wptr_q[c]] <= in_data;
        end
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_valid[c]                    = (occ_q[c] != '0);
    assign out_data[c*DATA_W +: DATA_W]    = mem_q[c][rptr_q[c]];
    assign occupancy[c*OCC_W +: OCC_W]     = occ_q[c];
  end

  assign drop_err = err_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_source_operand_router.sv
// Directed and random stimulus for source_operand_router, checked against a
// queue-per-channel reference model with a saturating drop counter.
module tb_source_operand_router;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [SEL_W-1:0]         in_sel;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*OCC_W-1:0]  occupancy;
  logic                     drop_err;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     err_clr;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel, plus the drop flag/counter.
  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic              m_err;
  int                m_cnt;

  source_operand_router #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy),
    .drop_err(drop_err), .drop_cnt(drop_cnt), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(exp_q[c].size() > 0));
      chk($sformatf("occupancy[%0d]", c), 32'(occupancy[c*OCC_W +: OCC_W]), exp_q[c].size());
      if (exp_q[c].size() > 0)
        chk($sformatf("out_data[%0d]", c), out_data[c*DATA_W +: DATA_W], exp_q[c][0]);
    end
    chk("drop_err", 32'(drop_err), 32'(m_err));
    chk("drop_cnt", 32'(drop_cnt), m_cnt);
  endtask

  // One clock: check in_ready for the current inputs, advance model and DUT,
  // then check all outputs 1 time unit after the edge.
  task automatic tick();
    logic              exp_rdy;
    logic              legal;
    logic              acc;
    logic [NUM_CH-1:0] popv;
    #1;
    legal   = (int'(in_sel) < NUM_CH);
    exp_rdy = 1'b1;
    if (legal) exp_rdy = (exp_q[in_sel].size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    for (int c = 0; c < NUM_CH; c++) popv[c] = (exp_q[c].size() > 0) && out_ready[c];
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) if (popv[c]) void'(exp_q[c].pop_front());
    if (acc && legal) exp_q[in_sel].push_back(in_data);
    if (err_clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end else if (acc && !legal) begin
      m_err = 1'b1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input int sel, input logic [31:0] d,
                       input logic [NUM_CH-1:0] rdy);
    in_valid  = v;
    in_sel    = SEL_W'(sel);
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    err_clr = 1'b0;
    drive(1'b0, 0, 32'h0, '0);
    model_clear();
    #3;
    check_outputs();
    chk("reset out_data", out_data[31:0] | out_data[63:32] | out_data[95:64], 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single push to channel 2, then pop
    drive(1'b1, 2, 32'hDEADBEEF, '0);
    tick();
    chk("t1 out_valid", 32'(out_valid), 32'b100);
    chk("t1 ch2 data", out_data[64 +: 32], 32'hDEADBEEF);
    drive(1'b0, 0, 32'h0, 3'b100);
    tick();
    chk("t1 ch2 empty", 32'(out_valid[2]), 32'h0);

    // 2: fill channel 1 with consumer stalled, then drain while 0x33 waits
    drive(1'b1, 1, 32'h11, '0);
    tick();
    drive(1'b1, 1, 32'h22, '0);
    tick();
    drive(1'b1, 1, 32'h33, '0);
    #1 chk("t2 in_ready full", 32'(in_ready), 32'h0);
    tick();
    chk("t2 occ1", 32'(occupancy[2*OCC_W-1:OCC_W]), 32'd2);
    out_ready = 3'b010;
    tick();
    chk("t2 head after pop", out_data[32 +: 32], 32'h22);
    tick();
    drive(1'b0, 0, 32'h0, 3'b010);
    chk("t2 head 0x33", out_data[32 +: 32], 32'h33);
    tick();
    tick();

    // 3: channel 0 with one entry, simultaneous push/pop across pointer wrap
    drive(1'b1, 0, 32'h5A, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0, (i == 0) ? 32'hA5 : $urandom, 3'b001);
      tick();
      chk("t3 occ0 steady", 32'(occupancy[OCC_W-1:0]), 32'd1);
    end
    drive(1'b0, 0, 32'h0, 3'b001);
    tick();

    // 4: illegal select flood, saturation, then clear colliding with a drop
    drive(1'b1, 3, 32'h0, '0);
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      tick();
    end
    chk("t4 drop_cnt sat", 32'(drop_cnt), 32'd255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4 clr cnt", 32'(drop_cnt), 32'd0);
    chk("t4 clr err", 32'(drop_err), 32'd0);
    drive(1'b0, 0, 32'h0, '0);
    tick();

    // 5: fill every channel, then asynchronous reset mid-cycle
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      drive(1'b1, i % NUM_CH, $urandom, '0);
      tick();
    end
    drive(1'b0, 0, 32'h0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t5 async out_valid", 32'(out_valid), 32'h0);
    chk("t5 async occupancy", 32'(occupancy), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 0, 32'h1, '0);
    tick();
    chk("t5 post-reset occ0", 32'(occupancy[OCC_W-1:0]), 32'd1);
    drive(1'b0, 0, 32'h0, 3'b001);
    tick();

    // 6: idle input with toggling select/data
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, $urandom_range(0, 3), $urandom, '0);
      tick();
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
            NUM_CH'($urandom_range(0, 7)));
      err_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
